decoder_scan_nto2n: RTL and testbench

Parametrised, registered N-to-2^N decoder with active-low one-cold outputs and 74138-style three-input enable gating. It adds an auto-scan mode in which an internal counter steps through every output with a programmable dwell time. It is the successor to the fixed 3-to-8 combinational decoder. It sits between control logic and multiplexed loads such as display digits, keypad columns or chip-selects.

---
 rtl/decoder_scan_nto2n.sv | 148 ++++++++++++++
 tb/tb_decoder_scan_nto2n.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N one-cold decoder with 74138-style enables and auto-scan.
// Ports: clk_i, rst_n_i, g1_en_i, g2a_en_n_i, g2b_en_n_i, mode_i, select_i, dwell_i -> yn_o, slot_o, wrap_o.
// Optional macro DECODER_SCAN_BLANK_EN inserts one all-ones cycle between scan slots.
module decoder_scan_nto2n #(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  g1_en_i,
  input  logic                  g2a_en_n_i,
  input  logic                  g2b_en_n_i,
  input  logic                  mode_i,
  input  logic [SEL_W-1:0]      select_i,
  input  logic [DWELL_W-1:0]    dwell_i,
  output logic [(1<<SEL_W)-1:0] yn_o,
  output logic [SEL_W-1:0]      slot_o,
  output logic                  wrap_o
);

  localparam int NOUT = 1 << SEL_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] DRIVE = 2'd1;
`ifdef DECODER_SCAN_BLANK_EN
  localparam logic [1:0] BLANK = 2'd2;
`endif

  localparam logic [NOUT-1:0] ONE = NOUT'(1);

  logic [1:0]         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   slot_q, slot_d;
  logic [NOUT-1:0]    yn_q, yn_d;
  logic [SEL_W-1:0]   slot_o_q, slot_o_d;
  logic               wrap_q, wrap_d;

  logic               en;
  logic               scan_ok;
  logic [SEL_W-1:0]   slot_nxt;
  logic [NOUT-1:0]    idle_yn;
  logic [SEL_W-1:0]   idle_slot;

  always_comb begin
    en        = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
    scan_ok   = en & mode_i;
    slot_nxt  = slot_q + SEL_W'(1);
    idle_yn   = en ? ~(ONE << select_i) : '1;
    idle_slot = en ? select_i : '0;

    state_d  = state_q;
    cnt_d    = cnt_q;
    slot_d   = slot_q;
    yn_d     = yn_q;
    slot_o_d = slot_o_q;
    wrap_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (scan_ok) begin
          state_d  = DRIVE;
          cnt_d    = '0;
          slot_d   = '0;
          yn_d     = ~ONE;
          slot_o_d = '0;
        end else begin
          yn_d     = idle_yn;
          slot_o_d = idle_slot;
        end
      end
      DRIVE: begin
        if (!scan_ok) begin
          // disable wins over any advance or wrap in the same cycle
          state_d  = IDLE;
          cnt_d    = '0;
          slot_d   = '0;
          yn_d     = idle_yn;
          slot_o_d = idle_slot;
        end else if (cnt_q >= dwell_i) begin
          // >= so a dwell shrink below the count advances at once
          cnt_d  = '0;
          slot_d = slot_nxt;
`ifdef DECODER_SCAN_BLANK_EN
          state_d  = BLANK;
          yn_d     = '1;
          slot_o_d = '0;
`else
          yn_d     = ~(ONE << slot_nxt);
          slot_o_d = slot_nxt;
          wrap_d   = (slot_nxt == '0);
`endif
        end else begin
          cnt_d    = cnt_q + DWELL_W'(1);
          yn_d     = ~(ONE << slot_q);
          slot_o_d = slot_q;
        end
      end
`ifdef DECODER_SCAN_BLANK_EN
      BLANK: begin
        if (!scan_ok) begin
          state_d  = IDLE;
          cnt_d    = '0;
          slot_d   = '0;
          yn_d     = idle_yn;
          slot_o_d = idle_slot;
        end else begin
          // slot already advanced on entry to BLANK
          state_d  = DRIVE;
          cnt_d    = '0;
          yn_d     = ~(ONE << slot_q);
          slot_o_d = slot_q;
          wrap_d   = (slot_q == '0);
        end
      end
`endif
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        slot_d   = '0;
        yn_d     = '1;
        slot_o_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      slot_q   <= '0;
      yn_q     <= '1;
      slot_o_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      slot_q   <= slot_d;
      yn_q     <= yn_d;
      slot_o_q <= slot_o_d;
      wrap_q   <= wrap_d;
    end
  end

  assign yn_o   = yn_q;
  assign slot_o = slot_o_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_decoder_scan_nto2n.sv
// Scoreboard bench for decoder_scan_nto2n (SEL_W=3, DWELL_W=8).
// Reference model pushes expected outputs at each edge; a monitor compares them.
module tb_decoder_scan_nto2n;

  localparam int SEL_W   = 3;
  localparam int DWELL_W = 8;
  localparam int NOUT    = 1 << SEL_W;
`ifdef DECODER_SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               g1 = 1'b1;
  logic               g2a = 1'b0;
  logic               g2b = 1'b0;
  logic               mode = 1'b0;
  logic [SEL_W-1:0]   sel = '0;
  logic [DWELL_W-1:0] dwell = '0;
  logic [NOUT-1:0]    yn;
  logic [SEL_W-1:0]   slot;
  logic               wrap;

  decoder_scan_nto2n #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .g1_en_i(g1), .g2a_en_n_i(g2a), .g2b_en_n_i(g2b),
    .mode_i(mode), .select_i(sel), .dwell_i(dwell),
    .yn_o(yn), .slot_o(slot), .wrap_o(wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NOUT-1:0]  yn;
    logic [SEL_W-1:0] slot;
    logic             wrap;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NOUT-1:0] one_cold(int idx, bit any);
    logic [NOUT-1:0] r;
    for (int k = 0; k < NOUT; k++) r[k] = !(any && k == idx);
    return r;
  endfunction

  // reference model: scan position as (slot, cycles spent in slot)
  bit   m_scan = 0;
  bit   m_blank = 0;
  int   m_cur = 0;
  int   m_age = 0;
  bit   m_en;
  exp_t m_e;

  always @(negedge rst_n) begin
    m_scan = 0;
    m_blank = 0;
    q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_en = g1 && !g2a && !g2b;
      m_e.wrap = 1'b0;
      if (!m_en || !mode) begin
        m_scan = 0;
        m_e.yn = one_cold(int'(sel), m_en);
        m_e.slot = m_en ? sel : '0;
      end else if (!m_scan) begin
        m_scan = 1; m_cur = 0; m_age = 0; m_blank = 0;
        m_e.yn = one_cold(0, 1);
        m_e.slot = '0;
      end else if (m_blank) begin
        m_blank = 0;
        m_e.yn = one_cold(m_cur, 1);
        m_e.slot = SEL_W'(m_cur);
        m_e.wrap = (m_cur == 0);
      end else if (m_age >= int'(dwell)) begin
        m_age = 0;
        m_cur = (m_cur + 1) % NOUT;
        if (BLK == 1) begin
          m_blank = 1;
          m_e.yn = '1;
          m_e.slot = '0;
        end else begin
          m_e.yn = one_cold(m_cur, 1);
          m_e.slot = SEL_W'(m_cur);
          m_e.wrap = (m_cur == 0);
        end
      end else begin
        m_age++;
        m_e.yn = one_cold(m_cur, 1);
        m_e.slot = SEL_W'(m_cur);
      end
      q.push_back(m_e);
    end
  end

  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_yn", 64'(yn), 64'(8'hFF));
      chk("rst_slot", 64'(slot), 64'd0);
      chk("rst_wrap", 64'(wrap), 64'd0);
    end else if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("sb_yn", 64'(yn), 64'(mon_e.yn));
      chk("sb_slot", 64'(slot), 64'(mon_e.slot));
      chk("sb_wrap", 64'(wrap), 64'(mon_e.wrap));
    end
  end

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  wraps;
  int  period;
  bit  found;

  initial begin
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);
    chk("first_dir0", 64'(yn), 64'(8'b1111_1110));

    // direct decode
    sel = 3'd5;
    cyc(1);
    chk("dir5_yn", 64'(yn), 64'(8'b1101_1111));
    chk("dir5_slot", 64'(slot), 64'd5);
    sel = 3'd0;
    cyc(1);
    chk("dir0_yn", 64'(yn), 64'(8'b1111_1110));

    // enable gating
    g2a = 1'b1;
    sel = SEL_W'($urandom_range(0, NOUT - 1));
    cyc(1);
    chk("g2a_off", 64'(yn), 64'(8'hFF));
    g2a = 1'b0;
    g1 = 1'b0;
    sel = SEL_W'($urandom_range(0, NOUT - 1));
    cyc(1);
    chk("g1_off", 64'(yn), 64'(8'hFF));
    chk("g1_off_slot", 64'(slot), 64'd0);
    g1 = 1'b1;

    // scan, count wraps over 48 cycles
    dwell = 8'd2;
    mode = 1'b1;
    cyc(1);
    chk("entry_yn", 64'(yn), 64'(8'b1111_1110));
    wraps = 0;
    repeat (48) begin
      cyc(1);
      wraps += int'(wrap);
    end
    period = NOUT * (3 + BLK);
    chk("wrap_count", 64'(wraps), 64'(48 / period));

    // reset mid-scan at slot 4
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (slot == 3'd4 && yn == 8'b1110_1111) begin
        found = 1;
        break;
      end
      cyc(1);
    end
    chk("reach_slot4", 64'(found), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_yn", 64'(yn), 64'(8'hFF));
    chk("arst_slot", 64'(slot), 64'd0);
    chk("arst_wrap", 64'(wrap), 64'd0);
    mode = 1'b0;
    g1 = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    cyc(1);
    chk("post_rst_idle", 64'(yn), 64'(8'hFF));
    g1 = 1'b1;

    // dwell shrink
    dwell = 8'd10;
    mode = 1'b1;
    cyc(1);
    cyc(5);
    chk("shrink_pre", 64'(slot), 64'd0);
    dwell = 8'd2;
    cyc(1);
    if (BLK == 1) chk("shrink_adv", 64'(yn), 64'(8'hFF));
    else chk("shrink_adv", 64'(slot), 64'd1);

    // abort and re-entry
    cyc(1);
    sel = 3'd6;
    mode = 1'b0;
    cyc(1);
    chk("abort_yn", 64'(yn), 64'(8'b1011_1111));
    mode = 1'b1;
    cyc(1);
    chk("reentry_slot", 64'(slot), 64'd0);
    chk("reentry_yn", 64'(yn), 64'(8'b1111_1110));

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      g1  = ($urandom_range(0, 39) != 0);
      g2a = ($urandom_range(0, 59) == 0);
      g2b = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) dwell = DWELL_W'($urandom_range(0, 4));
      sel = SEL_W'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      cyc(1);
    end

    @(negedge clk);
    #1;
    chk("sb_drain", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
